par2ser8: RTL and testbench

PAR2SER8 -- requirements
Module: par2ser8

---
 rtl/par2ser_pkg.sv | 12 +
 rtl/bit_index_ctr.sv | 34 +++
 rtl/par2ser8.sv | 102 ++++++++++
 tb/tb_par2ser8.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared widths and FSM state encoding for the 8-bit parallel-to-serial converter.
// The PARITY state exists only when PAR2SER_PARITY_EN is defined.
package par2ser_pkg;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

`ifdef PAR2SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/bit_index_ctr.sv
// Bit-select index: loads the start index, steps up (LSB first) or down (MSB first).
// Flags the start and terminal positions; holds whenever step is low.
module bit_index_ctr
  import par2ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             lsb_first,
  output logic [IDX_W-1:0] idx,
  output logic             at_start,
  output logic             term
);

  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] term_idx;

  assign start_idx = {IDX_W{~lsb_first}};
  assign term_idx  = {IDX_W{lsb_first}};
  assign at_start  = (idx == start_idx);
  assign term      = (idx == term_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (load) begin
      idx <= start_idx;
    end else if (step) begin
      idx <= lsb_first ? idx + 1'b1 : idx - 1'b1;
    end
  end

endmodule

// File: rtl/par2ser8.sv
// 8-bit parallel-to-serial shifter; first bit one cycle after load, ser_ready=0 stalls indefinitely.
// Define PAR2SER_PARITY_EN to append an even-parity bit as a ninth frame bit.
module par2ser8
  import par2ser_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [IDX_W-1:0]  idx;
  logic              at_start;
  logic              term;
  logic              load;
  logic              xfer;

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign ser_valid = (state != IDLE);
  assign load      = in_valid & in_ready;
  assign xfer      = ser_valid & ser_ready;

  bit_index_ctr u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (xfer && (state == SHIFT)),
    .lsb_first (LSB_FIRST),
    .idx       (idx),
    .at_start  (at_start),
    .term      (term)
  );

  // hold only loads in IDLE, so it is frozen for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            hold  <= in_data;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer && term) begin
`ifdef PAR2SER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef PAR2SER_PARITY_EN
        PARITY: begin
          if (xfer) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ser_out   = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    case (state)
      SHIFT: begin
        ser_out   = hold[idx];
        ser_first = at_start;
`ifdef PAR2SER_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = term;
`endif
      end
`ifdef PAR2SER_PARITY_EN
      PARITY: begin
        ser_out  = ^hold;
        ser_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_par2ser8.sv
// Directed bench for par2ser8: one LSB-first and one MSB-first instance share all inputs.
module tb_par2ser8;
`ifdef PAR2SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;

  logic l_in_ready, l_ser_valid, l_ser_out, l_ser_first, l_ser_last, l_busy;
  logic m_in_ready, m_ser_valid, m_ser_out, m_ser_first, m_ser_last, m_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  par2ser8 #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_out(l_ser_out), .ser_first(l_ser_first), .ser_last(l_ser_last), .busy(l_busy)
  );

  par2ser8 #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_out(m_ser_out), .ser_first(m_ser_first), .ser_last(m_ser_last), .busy(m_busy)
  );

  // stimulus only: present a word for one edge, leave the bench just after the edge
  task automatic load_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ser_ready = 1'b1;
    #12;
    n_checks++;
    if ({l_in_ready, l_busy, l_ser_valid, l_ser_out, l_ser_first, l_ser_last} !== 6'b100000)
      $display("FAIL reset_lsb: got %b expected 100000",
               {l_in_ready, l_busy, l_ser_valid, l_ser_out, l_ser_first, l_ser_last});
    else n_pass++;
    n_checks++;
    if ({m_in_ready, m_busy, m_ser_valid, m_ser_out, m_ser_first, m_ser_last} !== 6'b100000)
      $display("FAIL reset_msb: got %b expected 100000",
               {m_in_ready, m_busy, m_ser_valid, m_ser_out, m_ser_first, m_ser_last});
    else n_pass++;
    n_checks++;
    if (dut_l.u_ctr.idx !== 3'd0) $display("FAIL reset_idx: got %0d expected 0", dut_l.u_ctr.idx);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lsb_a5;
    logic exp_bit [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    load_word(8'hA5);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({l_ser_valid, l_ser_out, l_ser_first, l_ser_last, l_in_ready, l_busy} !==
          {1'b1, exp_bit[i], (i == 0), (i == 7) && !PAR, 1'b0, 1'b1})
        $display("FAIL a5_bit%0d: got v/o/f/l/r/b=%b expected %b", i,
                 {l_ser_valid, l_ser_out, l_ser_first, l_ser_last, l_in_ready, l_busy},
                 {1'b1, exp_bit[i], (i == 0), (i == 7) && !PAR, 1'b0, 1'b1});
      else n_pass++;
      @(posedge clk); #1;
    end
`ifdef PAR2SER_PARITY_EN
    n_checks++;
    if ({l_ser_valid, l_ser_out, l_ser_last} !== 3'b101)
      $display("FAIL a5_parity: got v/o/l=%b expected 101", {l_ser_valid, l_ser_out, l_ser_last});
    else n_pass++;
    @(posedge clk); #1;
`endif
    n_checks++;
    if ({l_in_ready, l_ser_valid} !== 2'b10)
      $display("FAIL a5_idle: got ready/valid=%b expected 10", {l_in_ready, l_ser_valid});
    else n_pass++;
  endtask

  task automatic test_msb_81;
    logic exp_bit [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load_word(8'h81);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({m_ser_valid, m_ser_out, m_ser_first, m_ser_last} !==
          {1'b1, exp_bit[i], (i == 0), (i == 7) && !PAR})
        $display("FAIL msb81_bit%0d: got v/o/f/l=%b expected %b", i,
                 {m_ser_valid, m_ser_out, m_ser_first, m_ser_last},
                 {1'b1, exp_bit[i], (i == 0), (i == 7) && !PAR});
      else n_pass++;
      n_checks++;
      if (dut_m.u_ctr.idx !== 3'(7 - i))
        $display("FAIL msb81_idx%0d: got %0d expected %0d", i, dut_m.u_ctr.idx, 7 - i);
      else n_pass++;
      @(posedge clk); #1;
    end
`ifdef PAR2SER_PARITY_EN
    n_checks++;
    if ({m_ser_out, m_ser_last} !== 2'b01)
      $display("FAIL msb81_parity: got o/l=%b expected 01", {m_ser_out, m_ser_last});
    else n_pass++;
    @(posedge clk); #1;
`endif
    n_checks++;
    if (m_in_ready !== 1'b1) $display("FAIL msb81_idle: got %b expected 1", m_in_ready);
    else n_pass++;
  endtask

  task automatic test_stall_3c;
    logic exp_bit [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load_word(8'h3C);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        ser_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          n_checks++;
          if ({l_ser_valid, l_ser_out, dut_l.u_ctr.idx} !== {1'b1, 1'b1, 3'd2})
            $display("FAIL stall_cyc%0d: got v/o/idx=%b expected 11010", k,
                     {l_ser_valid, l_ser_out, dut_l.u_ctr.idx});
          else n_pass++;
        end
        ser_ready = 1'b1;
      end
      n_checks++;
      if ({l_ser_out, l_ser_last} !== {exp_bit[i], (i == 7) && !PAR})
        $display("FAIL stall_bit%0d: got o/l=%b expected %b", i,
                 {l_ser_out, l_ser_last}, {exp_bit[i], (i == 7) && !PAR});
      else n_pass++;
      @(posedge clk); #1;
    end
`ifdef PAR2SER_PARITY_EN
    @(posedge clk); #1;
`endif
    n_checks++;
    if (l_in_ready !== 1'b1) $display("FAIL stall_idle: got %b expected 1", l_in_ready);
    else n_pass++;
  endtask

  task automatic test_ignore_c6;
    logic exp_bit [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    load_word(8'hC6);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h11 * (i + 1));
      n_checks++;
      if ({l_in_ready, l_ser_out} !== {1'b0, exp_bit[i]})
        $display("FAIL ignore_bit%0d: got ready/o=%b expected %b", i,
                 {l_in_ready, l_ser_out}, {1'b0, exp_bit[i]});
      else n_pass++;
      if (i == 7) in_valid = 1'b0;
      @(posedge clk); #1;
    end
`ifdef PAR2SER_PARITY_EN
    n_checks++;
    if (l_ser_out !== 1'b0) $display("FAIL ignore_parity: got %b expected 0", l_ser_out);
    else n_pass++;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid;
    logic exp_bit [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load_word(8'h5A);
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if ({l_ser_out, dut_l.u_ctr.idx} !== {1'b1, 3'd4})
      $display("FAIL midrst_pre: got o/idx=%b expected 1100", {l_ser_out, dut_l.u_ctr.idx});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({l_ser_valid, l_in_ready, l_busy, l_ser_out, m_ser_valid, m_in_ready} !== 6'b010001)
      $display("FAIL midrst_async: got %b expected 010001",
               {l_ser_valid, l_in_ready, l_busy, l_ser_out, m_ser_valid, m_in_ready});
    else n_pass++;
    #2 rst_n = 1'b1;
    load_word(8'h96);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({l_ser_valid, l_ser_out, l_ser_first} !== {1'b1, exp_bit[i], (i == 0)})
        $display("FAIL midrst_bit%0d: got v/o/f=%b expected %b", i,
                 {l_ser_valid, l_ser_out, l_ser_first}, {1'b1, exp_bit[i], (i == 0)});
      else n_pass++;
      @(posedge clk); #1;
    end
`ifdef PAR2SER_PARITY_EN
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_frame_end;
`ifdef PAR2SER_PARITY_EN
    load_word(8'h07);
    repeat (8) begin @(posedge clk); #1; end
    n_checks++;
    if ({l_ser_valid, l_ser_out, l_ser_last} !== 3'b111)
      $display("FAIL parity_07: got v/o/l=%b expected 111", {l_ser_valid, l_ser_out, l_ser_last});
    else n_pass++;
    @(posedge clk); #1;
    load_word(8'h03);
    repeat (8) begin @(posedge clk); #1; end
    n_checks++;
    if ({l_ser_valid, l_ser_out, l_ser_last} !== 3'b101)
      $display("FAIL parity_03: got v/o/l=%b expected 101", {l_ser_valid, l_ser_out, l_ser_last});
    else n_pass++;
    @(posedge clk); #1;
`else
    load_word(8'h07);
    repeat (7) begin @(posedge clk); #1; end
    n_checks++;
    if ({l_ser_out, l_ser_last} !== 2'b01)
      $display("FAIL noparity_last: got o/l=%b expected 01", {l_ser_out, l_ser_last});
    else n_pass++;
    @(posedge clk); #1;
`endif
    n_checks++;
    if ({l_in_ready, l_ser_valid} !== 2'b10)
      $display("FAIL frame_end_idle: got ready/valid=%b expected 10", {l_in_ready, l_ser_valid});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lsb_a5();
    test_msb_81();
    test_stall_3c();
    test_ignore_c6();
    test_reset_mid();
    test_frame_end();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
